// File: rtl/vtiming_rx_pkg.sv
// vtiming_rx_pkg: shared types and constants for the video timing receiver.
//   state_e       - lock FSM states
//   DEF_*         - default counter widths and lock depth
//   P_*           - 480x272 panel timing, used by benches to build stimulus
package vtiming_rx_pkg;

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_e;

    localparam int DEF_HBITS       = 11;
    localparam int DEF_VBITS       = 10;
    localparam int DEF_LOCK_FRAMES = 2;

    localparam int P_HACTIVE = 480;
    localparam int P_HTOTAL  = 525;
    localparam int P_VACTIVE = 272;
    localparam int P_VFP     = 4;
    localparam int P_VSYNC   = 10;
    localparam int P_VBP     = 4;
    localparam int P_VTOTAL  = 290;

endpackage

// File: rtl/vtiming_rx_if.sv
// vtiming_rx_if: video timing stream into the receiver and its analysis results.
//   master - timing source / consumer side (drives syncs and DE, reads results)
//   slave  - vtiming_rx side
interface vtiming_rx_if #(
    parameter int HBITS = vtiming_rx_pkg::DEF_HBITS,
    parameter int VBITS = vtiming_rx_pkg::DEF_VBITS
);
    logic             hsync_i;
    logic             vsync_i;
    logic             de_i;
    logic [HBITS-1:0] x_o;
    logic [VBITS-1:0] y_o;
    logic             de_o;
    logic [HBITS-1:0] htotal_o;
    logic [VBITS-1:0] vtotal_o;
    logic             frame_o;
    logic             err_o;
    logic             locked_o;
    logic [HBITS-1:0] hact_o;
    logic [VBITS-1:0] vact_o;

    modport master (
        output hsync_i, vsync_i, de_i,
        input  x_o, y_o, de_o, htotal_o, vtotal_o, frame_o, err_o, locked_o, hact_o, vact_o
    );

    modport slave (
        input  hsync_i, vsync_i, de_i,
        output x_o, y_o, de_o, htotal_o, vtotal_o, frame_o, err_o, locked_o, hact_o, vact_o
    );
endinterface

// File: rtl/vtiming_rx_edge.sv
// vtiming_edge: registers one input sample and flags a high->low transition
// between the previous and current registered samples.
//   clk_i, rst_i - pixel clock, synchronous active-high reset
//   in_i         - raw level
//   fall_o       - one-clock pulse, aligned with the registered sample
module vtiming_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic fall_o
);
    logic smp_q, smp_d;
    logic prev_q, prev_d;

    always_comb begin
        smp_d  = in_i;
        prev_d = smp_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            smp_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            smp_q  <= smp_d;
            prev_q <= prev_d;
        end
    end

    // Both flops clear to 0, so a low input right after reset is not an edge.
    assign fall_o = prev_q & ~smp_q;
endmodule

// File: rtl/vtiming_rx.sv
// vtiming_rx: video timing receiver / analyser.
// Recovers active-area pixel position from HSYNC/VSYNC/DE, measures line and
// frame length, and declares lock after LOCK_FRAMES matching frames.
//   clk_i, rst_i - pixel clock, synchronous active-high reset
//   vif (slave)  - syncs/DE in; x/y/de_o (2-clk latency), htotal/vtotal,
//                  frame/err pulses, locked, hact/vact
// Optional: define VTIMING_RX_ACTIVE_MEASURE_EN to measure active width and
// height (hact_o/vact_o) and check them while locked; otherwise both read 0.
module vtiming_rx
    import vtiming_rx_pkg::*;
#(
    parameter int HBITS       = DEF_HBITS,
    parameter int VBITS       = DEF_VBITS,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    vtiming_rx_if.slave vif
);
    localparam logic [HBITS-1:0] HMAX   = '1;
    localparam logic [VBITS-1:0] VMAX   = '1;
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    logic hfall, vfall;
    logic de_q, de_d, dep_q, dep_d;
    logic de_fall;

    state_e           state_q, state_d;
    logic [HBITS-1:0] hcnt_q, hcnt_d, htotal_q, htotal_d, ref_h_q, ref_h_d;
    logic [VBITS-1:0] vcnt_q, vcnt_d, vtotal_q, vtotal_d, ref_v_q, ref_v_d;
    logic [HBITS-1:0] xcnt_q, xcnt_d, x_q, x_d;
    logic [VBITS-1:0] ycnt_q, ycnt_d, y_q, y_d;
    logic [3:0]       match_q, match_d;
    logic             skip_q, skip_d;
    logic             de_o_q, de_o_d, frame_q, frame_d, err_q, err_d, locked_q, locked_d;
    logic [HBITS-1:0] line_len;
    logic [VBITS-1:0] frame_len;
    logic             ovf, line_bad, act_bad;

    vtiming_edge u_hedge (.clk_i(clk_i), .rst_i(rst_i), .in_i(vif.hsync_i), .fall_o(hfall));
    vtiming_edge u_vedge (.clk_i(clk_i), .rst_i(rst_i), .in_i(vif.vsync_i), .fall_o(vfall));

    assign de_fall = dep_q & ~de_q;

`ifdef VTIMING_RX_ACTIVE_MEASURE_EN
    logic [HBITS-1:0] hact_q, hact_d, hpix_q, hpix_d;
    logic [VBITS-1:0] vact_q, vact_d, vlin_q, vlin_d;
    logic             lde_q, lde_d, closed;

    // Blanking lines carry no width information, so hact only tracks lines
    // that actually contained DE.
    always_comb begin
        closed = hfall & lde_q;
        hpix_d = hfall ? HBITS'(de_q) : hpix_q + HBITS'(de_q);
        lde_d  = hfall ? de_q : (lde_q | de_q);
        hact_d = closed ? hpix_q : hact_q;
        vlin_d = vlin_q + VBITS'(closed);
        vact_d = vact_q;
        if (vfall) begin
            vact_d = vlin_d;
            vlin_d = '0;
        end
        act_bad = (state_q == LOCKED) &&
                  ((closed && hpix_q != hact_q) || (vfall && vact_d != vact_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hact_q <= '0; hpix_q <= '0; vact_q <= '0; vlin_q <= '0; lde_q <= 1'b0;
        end else begin
            hact_q <= hact_d; hpix_q <= hpix_d; vact_q <= vact_d; vlin_q <= vlin_d; lde_q <= lde_d;
        end
    end

    assign vif.hact_o = hact_q;
    assign vif.vact_o = vact_q;
`else
    assign act_bad    = 1'b0;
    assign vif.hact_o = '0;
    assign vif.vact_o = '0;
`endif

    always_comb begin
        de_d     = vif.de_i;
        dep_d    = de_q;
        hcnt_d   = hcnt_q + 1'b1;
        htotal_d = htotal_q;
        vcnt_d   = vcnt_q;
        vtotal_d = vtotal_q;
        ovf      = 1'b0;
        line_len  = (hcnt_q == HMAX) ? HMAX : hcnt_q + 1'b1;
        // A line closing on the frame-start edge belongs to the closing frame.
        frame_len = (hfall && vcnt_q != VMAX) ? vcnt_q + 1'b1 : vcnt_q;

        if (hfall) begin
            hcnt_d   = '0;
            htotal_d = line_len;
            vcnt_d   = frame_len;
            if (vcnt_q == VMAX - 1'b1 && !vfall) ovf = 1'b1;
        end else if (hcnt_q == HMAX) begin
            hcnt_d = HMAX;
        end else if (hcnt_q == HMAX - 1'b1) begin
            ovf = 1'b1;
        end
        if (vfall) begin
            vtotal_d = frame_len;
            vcnt_d   = '0;
        end

        x_d    = hfall ? '0 : xcnt_q;
        xcnt_d = x_d + HBITS'(de_q);
        y_d    = vfall ? '0 : ycnt_q;
        ycnt_d = y_d + VBITS'(de_fall);

        // After a mid-line frame start, the next line close is partial: skip it.
        skip_d   = vfall ? ~hfall : (hfall ? 1'b0 : skip_q);
        line_bad = hfall && !skip_q && (line_len != ref_h_q);

        state_d = state_q;
        ref_h_d = ref_h_q;
        ref_v_d = ref_v_q;
        match_d = match_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH:  if (vfall) state_d = MEASURE;
            MEASURE: if (vfall) begin
                ref_h_d = htotal_d;
                ref_v_d = vtotal_d;
                match_d = 4'd1;
                state_d = (LOCK_FRAMES == 1) ? LOCKED : CHECK;
            end
            CHECK, LOCKED: begin
                if (line_bad || act_bad || (vfall && vtotal_d != ref_v_q)) begin
                    err_d   = 1'b1;
                    state_d = MEASURE;
                end else if (vfall && state_q == CHECK) begin
                    match_d = match_q + 1'b1;
                    if (match_d >= LOCK_N) state_d = LOCKED;
                end
            end
            default: state_d = SEARCH;
        endcase
        if (ovf) begin
            err_d   = 1'b1;
            state_d = SEARCH;
        end

        locked_d = (state_d == LOCKED);
        frame_d  = vfall;
        de_o_d   = de_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEARCH;
            de_q <= 1'b0; dep_q <= 1'b0;
            hcnt_q <= '0; htotal_q <= '0; ref_h_q <= '0; xcnt_q <= '0; x_q <= '0;
            vcnt_q <= '0; vtotal_q <= '0; ref_v_q <= '0; ycnt_q <= '0; y_q <= '0;
            match_q <= '0; skip_q <= 1'b0;
            de_o_q <= 1'b0; frame_q <= 1'b0; err_q <= 1'b0; locked_q <= 1'b0;
        end else begin
            state_q <= state_d;
            de_q <= de_d; dep_q <= dep_d;
            hcnt_q <= hcnt_d; htotal_q <= htotal_d; ref_h_q <= ref_h_d; xcnt_q <= xcnt_d; x_q <= x_d;
            vcnt_q <= vcnt_d; vtotal_q <= vtotal_d; ref_v_q <= ref_v_d; ycnt_q <= ycnt_d; y_q <= y_d;
            match_q <= match_d; skip_q <= skip_d;
            de_o_q <= de_o_d; frame_q <= frame_d; err_q <= err_d; locked_q <= locked_d;
        end
    end

    assign vif.x_o      = x_q;
    assign vif.y_o      = y_q;
    assign vif.de_o     = de_o_q;
    assign vif.htotal_o = htotal_q;
    assign vif.vtotal_o = vtotal_q;
    assign vif.frame_o  = frame_q;
    assign vif.err_o    = err_q;
    assign vif.locked_o = locked_q;
endmodule

// File: doc/vtiming_rx.md
Name: vtiming_rx

Overview:
Video timing receiver/analyser; the sink-side counterpart of the horizontal/vertical sync generators. It samples the active-low HSYNC/VSYNC and the DE stream on the pixel clock, and recovers the pixel position (x, y) inside the active area. It also measures line length and frame height, and declares lock once the timing is stable. It sits in front of capture/overlay logic and is also a self-check monitor on our own VGA/LCD timing generators.

Parameters:
HBITS, 11, width of horizontal counters (max line length 2^HBITS-1 clocks)
VBITS, 10, width of vertical counters (max frame height 2^VBITS-1 lines)
LOCK_FRAMES, 2, consecutive matching frames required to assert locked_o (1..15)

Ports:
clk_i  in  1  pixel clock; only clock
rst_i  in  1  synchronous reset, active-high
hsync_i  in  1  horizontal sync, active-low
vsync_i  in  1  vertical sync, active-low
de_i  in  1  data enable (active pixel), active-high
x_o  out  HBITS  pixel index within the active line, valid when de_o=1
y_o  out  VBITS  active-line index within the frame, valid when de_o=1
de_o  out  1  de_i delayed to align with x_o/y_o
htotal_o  out  HBITS  last measured line length, in clocks
vtotal_o  out  VBITS  last measured frame height, in lines
frame_o  out  1  one-clock pulse at each frame start (vsync falling edge)
err_o  out  1  one-clock pulse on a timing mismatch or counter overflow
locked_o  out  1  timing stable for LOCK_FRAMES frames
hact_o  out  HBITS  active pixels per line (optional feature)
vact_o  out  VBITS  active lines per frame (optional feature)

Behaviour:
- Reset: every output is 0; all counters are 0; state is SEARCH. Reset dominates any input event in the same cycle.
- Input stage: hsync_i, vsync_i and de_i are each registered once.
- Edge detection:
  - hfall = registered hsync high → current sample low; this is the line start.
  - vfall = the same on vsync; this is the frame start.
- Horizontal counting:
  - hcnt increments every clock.
  - On hfall: htotal_o <= hcnt+1 and hcnt <= 0.
  - Overflow: hcnt reaching all-ones without an hfall → hcnt saturates, err_o pulses, state → SEARCH.
- Vertical counting:
  - vcnt increments on each hfall.
  - On vfall: vtotal_o <= vcnt (number of hfalls in the frame) and vcnt <= 0.
  - Saturation is handled the same way as for hcnt.
- Simultaneous hfall and vfall: the line is counted into the closing frame first, then vcnt <= 0.
- Position outputs:
  - x_o increments on each de cycle and clears on hfall.
  - y_o increments on the first de-low cycle after a de run, and clears on vfall.
  - Alignment: de_o, x_o and y_o are registered together with 2 clocks of latency from de_i. The first active pixel shows x_o=0, y_o=0.
- FSM (the state transitions below drive locked_o):
  - SEARCH: wait for vfall → MEASURE.
  - MEASURE: at the next vfall, store ref_h=htotal and ref_v=vtotal, set match=1 → CHECK. If LOCK_FRAMES=1, go directly to LOCKED.
  - CHECK: on each hfall, a line length different from ref_h → err_o, → MEASURE. On vfall with vtotal==ref_v, match++; when match reaches LOCK_FRAMES → LOCKED. On vfall with vtotal≠ref_v → err_o, → MEASURE.
  - LOCKED: locked_o=1. The same line and frame checks apply; any mismatch → err_o, locked_o <= 0, → MEASURE.
- Line-length check exemption: the partial line before the first hfall after a frame start is not checked.
- frame_o pulses on every vfall in every state.

Optional Feature:
Macro: VTIMING_RX_ACTIVE_MEASURE_EN
- Defined: on each hfall, hact_o <= the number of de cycles in the closed line. On each vfall, vact_o <= the number of lines that contained de. A change in either value while LOCKED raises err_o and drops to MEASURE.
- Undefined: hact_o and vact_o are tied to 0, no measurement logic is built, and no active-area check is done.

Decomposition:
- Package vtiming_rx_pkg holds:
  - the state enum {SEARCH, MEASURE, CHECK, LOCKED};
  - the default HBITS/VBITS/LOCK_FRAMES constants;
  - the 480x272 panel timing constants (vactive 272, vfp 4, vsync 10, vbp 4, vtotal 290; htotal 525, hactive 480) for benches.
- Sub-module vtiming_edge: a registered input plus a falling-edge pulse. It is instantiated for hsync and vsync.

Test Plan:
- 480x272 stimulus (htotal 525, vtotal 290), 3 frames → frame_o once per frame; htotal_o=525, vtotal_o=290; locked_o rises at the 3rd vfall (LOCK_FRAMES=2); err_o never pulses.
- Locked stream, one line shortened to 524 clocks → err_o pulses 1 clk at that hfall; locked_o falls; relock after 2 clean frames.
- Locked stream, de active pixel 479 of line 271 → x_o=479, y_o=271, de_o=1, exactly 2 clocks after de_i.
- hsync held high for 2048 clocks (HBITS=11) → err_o pulses once; state SEARCH; locked_o=0.
- rst_i asserted mid-frame while LOCKED → next clock all outputs are 0; relock needs SEARCH→MEASURE→2 frames.
- With VTIMING_RX_ACTIVE_MEASURE_EN: 480x272 stream → hact_o=480 after the first active line, vact_o=272 after the first frame. Without it: both stay 0.
